// File: rtl/inst_fetch.sv
// Instruction-fetch stage: holds the PC, issues one fetch at a time to a
// variable-latency instruction memory and presents the result on valid/ready.
module inst_fetch #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst
);

  typedef enum logic [1:0] {
    ISSUE = 2'b00,
    WAIT  = 2'b01,
    DROP  = 2'b10
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redirect_target;
  logic            slot_free;
  logic            resp_take;

  assign redirect_target = redirect_pc & ALIGN_MASK;
  assign slot_free       = !out_valid || out_ready;

  // rst_n gates the strobe so no request escapes while the memory is held in reset.
  assign imem_req  = rst_n && (state_q == ISSUE) && slot_free && !redirect_valid;
  assign imem_addr = pc_q;

  // A response is only kept when it arrives in WAIT without a competing redirect.
  assign resp_take = (state_q == WAIT) && imem_rvalid && !redirect_valid;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      ISSUE: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
        end else if (imem_req) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = imem_rvalid ? ISSUE : DROP;
        end else if (imem_rvalid) begin
          pc_d    = pc_q + PC_STEP;
          state_d = ISSUE;
        end
      end
      DROP: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
        end
        if (imem_rvalid) begin
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = ISSUE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC & ALIGN_MASK;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Output register: a redirect flush beats everything; a fresh response can
  // only land when the slot is already empty, so it never overwrites data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= NOP_INST;
    end else if (redirect_valid) begin
      out_valid <= 1'b0;
      out_inst  <= NOP_INST;
    end else if (resp_take) begin
      out_valid <= 1'b1;
      out_pc    <= pc_q;
      out_inst  <= imem_rdata;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_inst  <= NOP_INST;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a latency-programmable memory model feeds the
// DUT, tests push expected (pc, inst) pairs and a monitor pops them on handshake.
module tb_inst_fetch;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;

  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata  = '0;
  logic        inj_rvalid = 1'b0;
  logic [31:0] inj_rdata  = '0;
  int          mem_lat    = 1;
  int          mem_cnt    = 0;
  logic [63:0] mem_addr_q = '0;

  logic        w_req;
  logic [63:0] w_addr;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata  = '0;
  logic        w_out_valid;
  logic [63:0] w_out_pc;
  logic [31:0] w_out_inst;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  assign imem_rvalid = mem_rvalid | inj_rvalid;
  assign imem_rdata  = inj_rvalid ? inj_rdata : mem_rdata;

  always #5 clk = ~clk;

  inst_fetch u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst)
  );

  inst_fetch #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect_valid(1'b0), .redirect_pc(64'h0),
    .out_valid(w_out_valid), .out_ready(1'b1),
    .out_pc(w_out_pc), .out_inst(w_out_inst)
  );

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return {a[31:2] ^ 30'h2ABC_DEF1, 2'b11};
  endfunction

  // Memory model: samples the request at the edge, answers mem_lat edges later.
  always @(posedge clk) begin : mem_model
    logic        fire;
    logic [63:0] a;
    fire = rst_n && imem_req;
    a    = imem_addr;
    #1;
    mem_rvalid = 1'b0;
    if (!rst_n) begin
      mem_cnt = 0;
    end else begin
      if (fire) begin
        mem_cnt    = mem_lat;
        mem_addr_q = a;
      end
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = inst_of(mem_addr_q);
        end
      end
    end
  end

  // Latency-1 memory for the wrap instance.
  always @(posedge clk) begin : wrap_mem
    logic        fire;
    logic [63:0] a;
    fire = rst_n && w_req;
    a    = w_addr;
    #1;
    w_rvalid = fire;
    w_rdata  = inst_of(a);
  end

  // Handshake monitor: inputs change only just after posedge, so the negedge
  // view is exactly what the next edge will accept.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL handshake: unexpected out_pc=%h out_inst=%h, scoreboard empty", out_pc, out_inst);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_pc !== e.pc || out_inst !== e.inst) begin
          n_bad++;
          $display("FAIL handshake: got pc=%h inst=%h, expected pc=%h inst=%h", out_pc, out_inst, e.pc, e.inst);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_pc(input logic [63:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = inst_of(pc);
    sb.push_back(e);
  endtask

  task automatic do_reset(input int lat, input logic ready);
    tick();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    inj_rvalid     = 1'b0;
    mem_lat        = lat;
    tick();
    tick();
    rst_n     = 1'b1;
    out_ready = ready;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        n = i;
        break;
      end
    end
    n_cmp++;
    if (n < 0) begin
      n_bad++;
      $display("FAIL %s: out_valid never rose within 20 cycles", tag);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d expected instructions never delivered, required 0", tag, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1; mem_lat = 1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_inst !== NOP || out_pc !== 64'h0 || imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b inst=%h pc=%h req=%b, required 0/%h/0/0", out_valid, out_inst, out_pc, imem_req, NOP);
    end
    do_reset(1, 1'b1);
    expect_pc(64'h0); expect_pc(64'h4); expect_pc(64'h8);
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      n_bad++;
      $display("FAIL first_req: req=%b addr=%h, required 1/0", imem_req, imem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      wait_valid("first_fetch", n);
      n_cmp++;
      if (n !== 2) begin
        n_bad++;
        $display("FAIL fetch_spacing[%0d]: %0d cycles, required 2", k, n);
      end
    end
    tick();
    out_ready = 1'b0;
    drain("first_fetch");
  endtask

  task automatic test_backpressure();
    int n;
    do_reset(1, 1'b0);
    expect_pc(64'h0); expect_pc(64'h4);
    wait_valid("bp_first", n);
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_inst !== inst_of(64'h0) || imem_req !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: valid=%b pc=%h inst=%h req=%b, required 1/0/%h/0", k, out_valid, out_pc, out_inst, imem_req, inst_of(64'h0));
      end
      @(negedge clk);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h4) begin
      n_bad++;
      $display("FAIL bp_resume: req=%b addr=%h, required 1/4", imem_req, imem_addr);
    end
    wait_valid("bp_second", n);
    tick();
    out_ready = 1'b0;
    drain("backpressure");
  endtask

  task automatic test_redirect_wait();
    bit stale = 0;
    bit seen  = 0;
    do_reset(3, 1'b1);
    expect_pc(64'h1000);
    @(negedge clk);
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'h1002;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) stale = 1;
      if (imem_req) begin
        seen = 1;
        break;
      end
    end
    n_cmp++;
    if (stale !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_wait_stale: stale response visible=%b, required 0", stale);
    end
    n_cmp++;
    if (seen !== 1'b1 || imem_addr !== 64'h1000) begin
      n_bad++;
      $display("FAIL redir_wait_refetch: req_seen=%b addr=%h, required 1/1000", seen, imem_addr);
    end
    begin
      int n;
      wait_valid("redir_wait", n);
    end
    tick();
    out_ready = 1'b0;
    drain("redirect_wait");
  endtask

  task automatic test_redirect_coincident();
    int n;
    do_reset(2, 1'b1);
    expect_pc(64'h300);
    @(negedge clk);
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'h200;
    @(negedge clk);
    if (imem_rvalid !== 1'b1) $display("note: memory response not aligned with redirect");
    tick();
    redirect_pc = 64'h300;
    @(negedge clk);
    n_cmp++;
    if (imem_addr !== 64'h200 || imem_req !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL coincident_resp: addr=%h req=%b valid=%b, required 200/0/0", imem_addr, imem_req, out_valid);
    end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h300) begin
      n_bad++;
      $display("FAIL coincident_issue: req=%b addr=%h, required 1/300", imem_req, imem_addr);
    end
    wait_valid("coincident", n);
    tick();
    out_ready = 1'b0;
    drain("coincident");
  endtask

  task automatic test_flush();
    int n;
    do_reset(1, 1'b0);
    expect_pc(64'h40);
    wait_valid("flush_fill", n);
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'h40;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b0 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_pre: req=%b valid=%b, required 0/1", imem_req, out_valid);
    end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_inst !== NOP || imem_req !== 1'b1 || imem_addr !== 64'h40) begin
      n_bad++;
      $display("FAIL flush_post: valid=%b inst=%h req=%b addr=%h, required 0/%h/1/40", out_valid, out_inst, imem_req, imem_addr, NOP);
    end
    tick();
    out_ready = 1'b1;
    wait_valid("flush_fetch", n);
    tick();
    out_ready = 1'b0;
    drain("flush");
  endtask

  task automatic test_wrap();
    int n = -1;
    do_reset(1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (w_req !== 1'b1 || w_addr !== WRAP_PC) begin
      n_bad++;
      $display("FAIL wrap_first_req: req=%b addr=%h, required 1/%h", w_req, w_addr, WRAP_PC);
    end
    for (int k = 0; k < 2; k++) begin
      n = -1;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (w_out_valid) begin
          n = i;
          break;
        end
      end
      n_cmp++;
      if (n < 0 || w_out_pc !== (k == 0 ? WRAP_PC : 64'h0) || w_out_inst !== inst_of(k == 0 ? WRAP_PC : 64'h0)) begin
        n_bad++;
        $display("FAIL wrap_out[%0d]: seen=%0d pc=%h inst=%h, required pc=%h", k, n, w_out_pc, w_out_inst, (k == 0 ? WRAP_PC : 64'h0));
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset(3, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 64'h80;
    tick();
    redirect_valid = 1'b0;
    expect_pc(64'h80);
    wait_valid("areset_pre", n);
    tick();
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0 || out_inst !== NOP || out_pc !== 64'h0 || imem_addr !== 64'h0) begin
      n_bad++;
      $display("FAIL async_reset: req=%b valid=%b inst=%h pc=%h addr=%h, required 0/0/%h/0/0", imem_req, out_valid, out_inst, out_pc, imem_addr, NOP);
    end
    drain("areset_pre");
    tick();
    tick();
    rst_n = 1'b1;
    inj_rvalid = 1'b1; inj_rdata = 32'hDEAD_BEEF;
    expect_pc(64'h0);
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      n_bad++;
      $display("FAIL areset_refetch: req=%b addr=%h, required 1/0", imem_req, imem_addr);
    end
    tick();
    inj_rvalid = 1'b0;
    wait_valid("areset_post", n);
    tick();
    out_ready = 1'b0;
    drain("async_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_backpressure();
    test_redirect_wait();
    test_redirect_coincident();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
